// File: rtl/pc_seq_if.sv
// Fetch/decode-side bundle for the program-counter sequencer: decoder branch
// inputs, load-hazard stall, and the PC, squash and link-register outputs.
interface pc_seq_if;
  logic        ib;
  logic        bl;
  logic [31:0] bv;
  logic        ld_stall;
  logic [31:0] pc_out;
  logic [31:0] dec_pc_out;
  logic        fetch_en;
  logic        ispb_out;
  logic        lr_we;
  logic [31:0] lr_val;
  logic        stall_err;

  modport master (
    output ib, bl, bv, ld_stall,
    input  pc_out, dec_pc_out, fetch_en, ispb_out, lr_we, lr_val, stall_err
  );

  modport slave (
    input  ib, bl, bv, ld_stall,
    output pc_out, dec_pc_out, fetch_en, ispb_out, lr_we, lr_val, stall_err
  );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch/decode PCs, branch redirect with one squash
// bubble, BL link-register write and a sticky watchdog on long load stalls.
module pc_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 16
) (
  input logic     clk,
  input logic     rst,
  pc_seq_if.slave bus
);

  typedef enum logic {RUN, SQUASH} state_t;

  localparam logic [8:0] LIMIT = 9'(STALL_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        lr_we_q, lr_we_d;
  logic [31:0] lr_val_q, lr_val_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic        stall_err_q, stall_err_d;

  logic [8:0]  stall_cnt_inc;
  logic [31:0] branch_sum;
  logic        branch_take;

  assign stall_cnt_inc = {1'b0, stall_cnt_q} + 9'd1;
  assign branch_sum    = dec_pc_q + 32'd8 + bus.bv;
  assign branch_take   = (state_q == RUN) && !bus.ld_stall && bus.ib;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SQUASH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath; a stall freezes PCs and state but still runs the watchdog.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dec_pc_d    = dec_pc_q;
    lr_we_d     = 1'b0;
    lr_val_d    = lr_val_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;

    if (bus.ld_stall) begin
      stall_cnt_d = stall_cnt_inc[8] ? 8'hFF : stall_cnt_inc[7:0];
      if (stall_cnt_inc >= LIMIT) begin
        stall_err_d = 1'b1;
      end
    end else begin
      stall_cnt_d = 8'd0;
      dec_pc_d    = pc_q;
      if (branch_take) begin
        pc_d    = {branch_sum[31:2], 2'b00};
        state_d = SQUASH;
        if (bus.bl) begin
          lr_we_d  = 1'b1;
          lr_val_d = dec_pc_q + 32'd4;
        end
      end else begin
        pc_d    = pc_q + 32'd4;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      dec_pc_q    <= RESET_PC;
      lr_we_q     <= 1'b0;
      lr_val_q    <= 32'd0;
      stall_cnt_q <= 8'd0;
      stall_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      dec_pc_q    <= dec_pc_d;
      lr_we_q     <= lr_we_d;
      lr_val_q    <= lr_val_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign bus.pc_out     = pc_q;
  assign bus.dec_pc_out = dec_pc_q;
  assign bus.fetch_en   = ~bus.ld_stall;
  assign bus.ispb_out   = (state_q == SQUASH);
  assign bus.lr_we      = lr_we_q;
  assign bus.lr_val     = lr_val_q;
  assign bus.stall_err  = stall_err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: directed branch/stall/wrap scenarios followed by
// random traffic, checked against a rule-level reference model.
module tb_pc_seq;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          STALL_LIMIT = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dec_pc;
    logic        ispb;
    logic        lr_we;
    logic [31:0] lr_val;
    logic        stall_err;
    logic        fetch_en;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pc_seq_if bus ();

  pc_seq #(.RESET_PC(RESET_PC), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: architectural view of the sequencer after the next edge.
  logic [31:0] m_pc, m_dec, m_lr_val;
  logic        m_squash, m_lr_we, m_err;
  int          m_stall_run;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic r, input logic i, input logic b,
                               input logic [31:0] v, input logic s);
    exp_t e;
    @(negedge clk);
    rst = r; bus.ib = i; bus.bl = b; bus.bv = v; bus.ld_stall = s;
    if (r) begin
      m_pc = RESET_PC; m_dec = RESET_PC; m_squash = 1'b1;
      m_lr_we = 1'b0; m_lr_val = 32'd0; m_err = 1'b0; m_stall_run = 0;
    end else if (s) begin
      m_stall_run++;
      if (m_stall_run >= STALL_LIMIT) m_err = 1'b1;
      m_lr_we = 1'b0;
    end else begin
      m_stall_run = 0;
      if (!m_squash && i) begin
        logic [31:0] tgt;
        tgt = (m_dec + 32'd8 + v) & 32'hFFFF_FFFC;
        m_lr_we = b;
        if (b) m_lr_val = m_dec + 32'd4;
        m_dec = m_pc; m_pc = tgt; m_squash = 1'b1;
      end else begin
        m_lr_we = 1'b0;
        m_dec = m_pc; m_pc = m_pc + 32'd4; m_squash = 1'b0;
      end
    end
    e.pc = m_pc; e.dec_pc = m_dec; e.ispb = m_squash; e.lr_we = m_lr_we;
    e.lr_val = m_lr_val; e.stall_err = m_err; e.fetch_en = ~s;
    sb.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic stall(input int n, input logic with_ib);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, with_ib, 1'b1, 32'h40, 1'b1);
  endtask

  // Steer the model (and DUT) so that 'target' sits in decode in RUN state.
  task automatic branch_to(input logic [31:0] target);
    if (m_squash) nop(1);
    applyStimulus(1'b0, 1'b1, 1'b0, target - m_dec - 32'd8, 1'b0);
    nop(1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pc_out",     bus.pc_out,              e.pc);
        checkOutput("dec_pc_out", bus.dec_pc_out,          e.dec_pc);
        checkOutput("ispb_out",   {31'd0, bus.ispb_out},   {31'd0, e.ispb});
        checkOutput("lr_we",      {31'd0, bus.lr_we},      {31'd0, e.lr_we});
        checkOutput("lr_val",     bus.lr_val,              e.lr_val);
        checkOutput("stall_err",  {31'd0, bus.stall_err},  {31'd0, e.stall_err});
        checkOutput("fetch_en",   {31'd0, bus.fetch_en},   {31'd0, e.fetch_en});
      end
    end
  end

  initial begin
    logic [31:0] r;
    bus.ib = 1'b0; bus.bl = 1'b0; bus.bv = 32'd0; bus.ld_stall = 1'b0;

    // Boot sequence
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nop(4);

    // Plain branch and BL with negative offset
    branch_to(32'h100);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 1'b0);
    nop(2);
    branch_to(32'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
    nop(2);

    // Stall in RUN with ib ignored, then stall across the first SQUASH after BL
    stall(3, 1'b1);
    nop(1);
    branch_to(32'h300);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
    stall(2, 1'b1);
    nop(3);

    // Watchdog: burst of 3 stays clean, burst of 4 trips and stays sticky
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nop(2);
    stall(3, 1'b0);
    nop(1);
    stall(4, 1'b0);
    nop(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nop(2);

    // Address wrap, then reset in the middle of a SQUASH
    branch_to(32'hFFFF_FFF8);
    nop(2);
    branch_to(32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    nop(3);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 30),
                    r[0],
                    r[1] ? $urandom : {{18{r[13]}}, r[13:2], 2'b00},
                    ($urandom_range(0, 99) < 20));
    end
    nop(2);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    n_total++;
    if (sb.size() != 0)
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
